mdu: RTL and testbench

//   Multi-cycle multiply/divide unit with architectural HI/LO registers (MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO).

---
 rtl/mdu_if.sv | 25 ++
 rtl/mdu.sv | 210 +++++++++++++++++++++
 tb/tb_mdu.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Execute-stage handshake and result bundle for the multiply/divide unit.
// master = issuing pipeline side, slave = mdu.
interface mdu_if #(
   parameter int W = 32
);
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         flush;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   modport master (
      output start, op, in1, in2, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, in1, in2, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// Optional MDU_FAST_MUL_EN: single-cycle '*' multiply (IDLE -> FIN); divide is always 32-step.
module mdu #(
   parameter int W     = 32,
   parameter int CNT_W = 6
) (
   input  logic  clk,
   input  logic  resetn,
   mdu_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [W-1:0]       acc_hi_q, acc_hi_d;
   logic [W-1:0]       acc_lo_q, acc_lo_d;
   logic [W-1:0]       opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic [W-1:0]       raw1_q, raw1_d;
   logic [W-1:0]       hi_q, hi_d;
   logic [W-1:0]       lo_q, lo_d;
   logic               done_q, done_d;

   logic               signed_op_s;
   logic [W-1:0]       abs1_s;
   logic [W-1:0]       abs2_s;
   logic [W:0]         sum_s;
   logic [W:0]         rsh_s;
   logic               ge_s;
   logic [W-1:0]       diff_s;
   logic [W-1:0]       step_hi_s;
   logic [W-1:0]       step_lo_s;
`ifdef MDU_FAST_MUL_EN
   logic [2*W-1:0]     fast_prod_s;
`endif

   // Quotient/product sign and remainder sign fix-up; divide-by-zero returns all-ones / dividend.
   function automatic logic [2*W-1:0] fix_result(
      input logic         div,
      input logic         neg_res,
      input logic         neg_rem,
      input logic         dz,
      input logic [W-1:0] raw,
      input logic [W-1:0] h,
      input logic [W-1:0] l
   );
      logic [2*W-1:0] p;
      p = {h, l};
      if (div) begin
         if (dz) begin
            fix_result = {raw, {W{1'b1}}};
         end else begin
            fix_result = {(neg_rem ? -h : h), (neg_res ? -l : l)};
         end
      end else begin
         fix_result = neg_res ? -p : p;
      end
   endfunction

   assign signed_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign abs1_s      = (signed_op_s && bus.in1[W-1]) ? -bus.in1 : bus.in1;
   assign abs2_s      = (signed_op_s && bus.in2[W-1]) ? -bus.in2 : bus.in2;
`ifdef MDU_FAST_MUL_EN
   assign fast_prod_s = {{W{1'b0}}, abs1_s} * {{W{1'b0}}, abs2_s};
`endif

   // One radix-2 step: shift-add multiply (multiplier in acc_lo) or restoring divide.
   always_comb begin
      sum_s  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      rsh_s  = {acc_hi_q, acc_lo_q[W-1]};
      ge_s   = (rsh_s >= {1'b0, opnd_q});
      diff_s = rsh_s[W-1:0] - opnd_q;
      if (is_div_q) begin
         step_hi_s = ge_s ? diff_s : rsh_s[W-1:0];
         step_lo_s = {acc_lo_q[W-2:0], ge_s};
      end else begin
         step_hi_s = sum_s[W:1];
         step_lo_s = {sum_s[0], acc_lo_q[W-1:1]};
      end
   end

   // Next-state, datapath latching and HI/LO write selection.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      raw1_d    = raw1_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (bus.start) begin
               case (bus.op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     acc_hi_d  = {W{1'b0}};
                     acc_lo_d  = abs1_s;
                     opnd_d    = abs2_s;
                     is_div_d  = bus.op[1];
                     neg_res_d = signed_op_s && (bus.in1[W-1] ^ bus.in2[W-1]);
                     neg_rem_d = signed_op_s && bus.in1[W-1];
                     dz_d      = bus.op[1] && (bus.in2 == {W{1'b0}});
                     raw1_d    = bus.in1;
                     count_d   = {CNT_W{1'b0}};
                     state_d   = RUN;
`ifdef MDU_FAST_MUL_EN
                     if (!bus.op[1]) begin
                        {hi_d, lo_d} = fix_result(1'b0, signed_op_s && (bus.in1[W-1] ^ bus.in2[W-1]),
                                                  1'b0, 1'b0, bus.in1,
                                                  fast_prod_s[2*W-1:W], fast_prod_s[W-1:0]);
                        done_d  = 1'b1;
                        state_d = FIN;
                     end else begin
                        state_d = RUN;
                     end
`endif
                  end
                  OP_MTHI: hi_d = bus.in1;
                  OP_MTLO: lo_d = bus.in1;
                  default: state_d = IDLE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               acc_hi_d = step_hi_s;
               acc_lo_d = step_lo_s;
               count_d  = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               // Last step writes HI/LO so they already hold the result during the done cycle.
               if (count_q == CNT_W'(W-1)) begin
                  {hi_d, lo_d} = fix_result(is_div_q, neg_res_q, neg_rem_q, dz_q, raw1_q,
                                            step_hi_s, step_lo_s);
                  done_d  = 1'b1;
                  state_d = FIN;
               end else begin
                  state_d = RUN;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         count_q   <= {CNT_W{1'b0}};
         acc_hi_q  <= {W{1'b0}};
         acc_lo_q  <= {W{1'b0}};
         opnd_q    <= {W{1'b0}};
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         raw1_q    <= {W{1'b0}};
         hi_q      <= {W{1'b0}};
         lo_q      <= {W{1'b0}};
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         raw1_q    <= raw1_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: multiply, divide, MTHI/MTLO, flush and async reset.
module tb_mdu;

   logic clk;
   logic resetn;
   int   n_vec;
   int   n_err;
   logic [31:0] mhi;
   logic [31:0] mlo;

   mdu_if bus ();

   mdu dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op; inject a MTHI of 0xDEAD at loop cycle inj to prove starts are ignored while busy.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int exp_lat, input int inj);
      int   n;
      logic stable;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.in1 = a; bus.in2 = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      stable = 1'b1;
      while (!bus.done && n < 100) begin
         if (bus.hi !== mhi || bus.lo !== mlo || !bus.busy) stable = 1'b0;
         @(negedge clk);
         if (n == inj) begin
            bus.start = 1'b1; bus.op = 3'd4; bus.in1 = 32'h0000_DEAD;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check({tag, "_stable"}, {63'd0, stable}, 64'd1);
      check({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd1);
      check({tag, "_hilo"}, {bus.hi, bus.lo}, {ehi, elo});
      mhi = ehi; mlo = elo;
      @(posedge clk); #1;
      check({tag, "_idle"}, {62'd0, bus.busy, bus.done}, 64'd0);
   endtask

   initial begin
      int mul_lat;
      int n;
      logic seen_done;
`ifdef MDU_FAST_MUL_EN
      mul_lat = 1;
`else
      mul_lat = 33;
`endif
      n_vec = 0; n_err = 0;
      mhi = 32'd0; mlo = 32'd0;
      resetn = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.in1 = 32'd0; bus.in2 = 32'd0; bus.flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
      @(negedge clk); resetn = 1'b1;

      run_op("mult_neg",  3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, mul_lat, -1);
      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, mul_lat, -1);
      run_op("mult_min",  3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, mul_lat, -1);
      run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, -1);
      run_op("div_negd",  3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, -1);
      run_op("divu_zero", 3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 33, -1);
      run_op("div_zero_s",3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, -1);
      run_op("divu_big",  3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33, -1);
      run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 4);

      // MTHI then MTLO back-to-back
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.in1 = 32'h0000_1234;
      @(posedge clk); #1;
      check("mthi", {bus.busy, bus.done, bus.hi}, {2'b00, 32'h0000_1234});
      @(negedge clk);
      bus.op = 3'd5; bus.in1 = 32'h0000_5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("mtlo", {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, 32'h0000_1234, 32'h0000_5678});
      mhi = 32'h0000_1234; mlo = 32'h0000_5678;

      // flush squashes a same-cycle start, and a no-op code does nothing
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd4; bus.in1 = 32'h0BAD_0BAD; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.op = 3'd6;
      check("flush_beats_start", {bus.busy, bus.hi}, {1'b0, mhi});
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("noop_op", {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, mhi, mlo});

      // flush an in-flight DIVU
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd3; bus.in1 = 32'd100; bus.in2 = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
      end
      check("busy_before_flush", {63'd0, bus.busy}, 64'd1);
      @(negedge clk); bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush_idle", {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, mhi, mlo});
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) seen_done = 1'b1;
      end
      check("flush_no_done", {63'd0, seen_done}, 64'd0);

      // async reset mid-operation
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd0; bus.in1 = 32'd5; bus.in2 = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (bus.busy && n < 3) begin
         @(posedge clk); #1;
         n++;
      end
      #2 resetn = 1'b0;
      #1;
      check("async_reset", {bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
      @(negedge clk); resetn = 1'b1;
      mhi = 32'd0; mlo = 32'd0;
      run_op("after_reset", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
